// File: rtl/dmem_responder.sv
// Word-addressed data RAM that stalls the core for LATENCY cycles per access.
// It keeps a sticky misalignment flag and offers a combinational debug read port.
module dmem_responder #(
  parameter int AW      = 8,
  parameter int LATENCY = 2
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          MemRead,
  input  logic          MemWrite,
  input  logic [31:0]   Addr,
  input  logic [31:0]   WriteData,
  output logic [31:0]   ReadData,
  output logic          Stall,
  output logic          MisAlign,
  input  logic [AW-1:0] DbgAddr,
  output logic [31:0]   DbgData
);
  localparam int DEPTH = 1 << AW;
  localparam logic [3:0] CNT_INIT = 4'((LATENCY >= 2) ? (LATENCY - 2) : 0);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_wdata;
  logic          r_wr;
  logic [31:0]   r_rdata;
  logic          r_misalign;
  logic [31:0]   r_mem [DEPTH];

  logic          w_req;
  logic          w_aligned;
  logic          w_accept;
  logic          w_commit;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_wdata;
  logic          w_wr;
  logic          w_unused_addr;

  assign w_req         = MemRead | MemWrite;
  assign w_aligned     = (Addr[1:0] == 2'b00);
  assign w_accept      = (r_state == IDLE) && w_req && w_aligned;
  assign w_unused_addr = ^Addr[31:AW+2];

  // With LATENCY 1 the access commits straight out of IDLE using the live inputs.
  assign w_commit = !Reset && ((LATENCY == 1) ? w_accept
                                              : ((r_state == WAIT) && (r_cnt == 4'd0)));
  assign w_idx    = (r_state == IDLE) ? Addr[AW+1:2] : r_idx;
  assign w_wdata  = (r_state == IDLE) ? WriteData    : r_wdata;
  assign w_wr     = (r_state == IDLE) ? MemWrite     : r_wr;

  assign Stall    = !Reset && ((r_state == WAIT) || w_accept);
  assign ReadData = r_rdata;
  assign MisAlign = r_misalign;
  assign DbgData  = r_mem[DbgAddr];

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_rdata    <= 32'd0;
      r_misalign <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req && !w_aligned) r_misalign <= 1'b1;
          if (w_accept) begin
            if (LATENCY == 1) begin
              r_state <= DONE;
            end else begin
              r_state <= WAIT;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) r_state <= DONE;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      if (w_commit && !w_wr) r_rdata <= r_mem[w_idx];
    end
  end

  // Request capture; inputs are ignored after the accepting cycle.
  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_idx   <= Addr[AW+1:2];
      r_wdata <= WriteData;
      r_wr    <= MemWrite;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_commit && w_wr) r_mem[w_idx] <= w_wdata;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory port, consuming MemRead/MemWrite, Addr (the ALU result) and WriteData, and returning ReadData.
- Word-addressed RAM with a fixed, parameterised access latency. It raises Stall so the core freezes PC and register write-back until the access completes.
- Flags misaligned word accesses with a sticky error bit.
- Provides an asynchronous debug read port for benches and board display.

Parameters:
- AW, 8: word-index width; DEPTH = 2^AW words of 32 bits.
- LATENCY, 2: number of Stall cycles per accepted access; legal range 1..15.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- MemRead  in  1  load request from core.
- MemWrite  in  1  store request from core.
- Addr  in  32  byte address; word index = Addr[AW+1:2], upper bits ignored.
- WriteData  in  32  store data.
- ReadData  out  32  load result, registered.
- Stall  out  1  core must hold PC and suppress write-back while high.
- MisAlign  out  1  sticky: a request arrived with Addr[1:0] != 0.
- DbgAddr  in  AW  debug word index.
- DbgData  out  32  combinational read of mem[DbgAddr].

Behaviour:
- FSM states IDLE, WAIT, DONE; down-counter cnt, 4 bits.
- Request = MemRead | MemWrite.
- Accepted request = request in IDLE with Addr[1:0] == 0.
- IDLE:
  - On an accepted request, latch word index, WriteData and op (write if MemWrite, else read); Stall = 1 combinationally in this same cycle.
  - Next state is DONE if LATENCY == 1. Otherwise next state is WAIT with cnt = LATENCY-2.
- WAIT:
  - Stall = 1; all inputs ignored, latched values used.
  - If cnt == 0, go to DONE; else decrement cnt.
- Transition into DONE (same clock edge):
  - Write: mem[idx] <= latched data.
  - Read: ReadData <= mem[idx].
- DONE:
  - Stall = 0; the core completes the instruction this cycle.
  - Go to IDLE unconditionally. Request inputs are ignored here because they still belong to the just-served instruction.
- Timing: Stall is high for exactly LATENCY consecutive cycles, starting with the request cycle. DONE is the (LATENCY+1)th cycle and is the only cycle in which the core samples ReadData.
- ReadData holds its value until the next completed read; it is not updated by writes or misaligned requests.
- MemRead and MemWrite both high: treated as a write; ReadData is unchanged.
- Misaligned request in IDLE:
  - No memory access, Stall = 0, state stays IDLE.
  - MisAlign <= 1 on the next edge; it stays set until Reset.
- Address wrap: addresses differing only above bit AW+1 alias the same word.
- Reset (synchronous, edge with Reset = 1):
  - state <= IDLE, cnt <= 0, ReadData <= 0, MisAlign <= 0.
  - Stall is forced to 0 combinationally while Reset is high.
  - A pending access is aborted; a pending write is never committed.
  - Memory contents are not cleared.
- DbgData = mem[DbgAddr], combinational; it reflects a write from the DONE cycle onward.

Test Plan:
1. LATENCY=2, after Reset: store Addr=0x10, WriteData=0xDEADBEEF held 3 cycles -> Stall = 1,1,0; DbgAddr=4 gives DbgData=0xDEADBEEF in the DONE cycle; MisAlign = 0.
2. Then load Addr=0x10 -> Stall = 1,1,0; ReadData = 0xDEADBEEF in the DONE cycle and held afterwards through an idle cycle.
3. Load Addr=0x10, with Addr changed to 0x20 and WriteData toggled during WAIT -> ReadData = 0xDEADBEEF; mem[8] unchanged.
4. MemRead=1, Addr=0x13 in IDLE -> Stall = 0, MisAlign = 1 next cycle and still 1 after a following valid load; only Reset clears it.
5. Store Addr=0x20, value 0x12345678, with Reset asserted in the second stall cycle -> next cycle Stall = 0, state IDLE; DbgAddr=8 shows the prior value; ReadData = 0.
6. AW=8: store 0xA5A5A5A5 to Addr=0x400, then load Addr=0x0 -> ReadData = 0xA5A5A5A5. Back-to-back with LATENCY=1: store then load on consecutive instructions -> Stall pattern 1,0,1,0; load returns the stored value.
